// File: rtl/enemy_sprite_drawer.sv
// Enemy sprite renderer: on each accepted start, erases the rectangle at the
// previously drawn position (when built with ENEMY_SPRITE_ERASE_EN), then draws
// a solid SPRITE_W x SPRITE_H rectangle at the new position, one pixel per clock.
// Macro ENEMY_SPRITE_ERASE_EN: defined builds the ERASE pass and prev_* state;
// undefined always goes straight to DRAW and the sprite leaves a trail.
module enemy_sprite_drawer #(
   parameter int unsigned SPRITE_W  = 8,
   parameter int unsigned SPRITE_H  = 4,
   parameter logic [2:0]  BG_COLOUR = 3'b000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] enemy_x,
   input  logic [6:0] enemy_y,
   input  logic [2:0] enemy_colour,
   output logic       busy,
   output logic       plot,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       done
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned X_W   = 8;
   localparam int unsigned Y_W   = 7;
   localparam int unsigned C_W   = 3;
   localparam int unsigned X_MAX = 159;
   localparam int unsigned Y_MAX = 119;

   localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(SPRITE_W - 1);
   localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(SPRITE_H - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAW  = 2'd1,
      DONE  = 2'd2
`ifdef ENEMY_SPRITE_ERASE_EN
      , ERASE = 2'd3
`endif
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] col_q, col_d;
   logic [CNT_W-1:0] row_q, row_d;
   logic [X_W-1:0]   new_x_q, new_x_d;
   logic [Y_W-1:0]   new_y_q, new_y_d;
   logic [C_W-1:0]   new_colour_q, new_colour_d;

   logic             busy_q, busy_d;
   logic             plot_q, plot_d;
   logic [X_W-1:0]   vga_x_q, vga_x_d;
   logic [Y_W-1:0]   vga_y_q, vga_y_d;
   logic [C_W-1:0]   vga_colour_q, vga_colour_d;
   logic             done_q, done_d;

`ifdef ENEMY_SPRITE_ERASE_EN
   logic [X_W-1:0]   prev_x_q, prev_x_d;
   logic [Y_W-1:0]   prev_y_q, prev_y_d;
   logic             prev_valid_q, prev_valid_d;
`else
   // BG_COLOUR only matters when the erase pass is built
   logic             unused_bg;
   assign unused_bg = ^BG_COLOUR;
`endif

   logic             last_px;
   logic [X_W-1:0]   base_x;
   logic [Y_W-1:0]   base_y;
   logic [C_W-1:0]   pix_colour;
   logic [X_W:0]     pix_x;
   logic [Y_W:0]     pix_y;
   logic             in_pass;

   // State, counters and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         col_q        <= '0;
         row_q        <= '0;
         new_x_q      <= '0;
         new_y_q      <= '0;
         new_colour_q <= '0;
         busy_q       <= 1'b0;
         plot_q       <= 1'b0;
         vga_x_q      <= '0;
         vga_y_q      <= '0;
         vga_colour_q <= '0;
         done_q       <= 1'b0;
`ifdef ENEMY_SPRITE_ERASE_EN
         prev_x_q     <= '0;
         prev_y_q     <= '0;
         prev_valid_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         new_x_q      <= new_x_d;
         new_y_q      <= new_y_d;
         new_colour_q <= new_colour_d;
         busy_q       <= busy_d;
         plot_q       <= plot_d;
         vga_x_q      <= vga_x_d;
         vga_y_q      <= vga_y_d;
         vga_colour_q <= vga_colour_d;
         done_q       <= done_d;
`ifdef ENEMY_SPRITE_ERASE_EN
         prev_x_q     <= prev_x_d;
         prev_y_q     <= prev_y_d;
         prev_valid_q <= prev_valid_d;
`endif
      end
   end

   // Next state, scan counters, and the pixel to present in the next cycle
   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      row_d        = row_q;
      new_x_d      = new_x_q;
      new_y_d      = new_y_q;
      new_colour_d = new_colour_q;
`ifdef ENEMY_SPRITE_ERASE_EN
      prev_x_d     = prev_x_q;
      prev_y_d     = prev_y_q;
      prev_valid_d = prev_valid_q;
`endif
      last_px      = (col_q == COL_LAST) && (row_q == ROW_LAST);

      unique case (state_q)
         IDLE: begin
            if (start) begin
               new_x_d      = enemy_x;
               new_y_d      = enemy_y;
               new_colour_d = enemy_colour;
               col_d        = '0;
               row_d        = '0;
`ifdef ENEMY_SPRITE_ERASE_EN
               state_d      = prev_valid_q ? ERASE : DRAW;
`else
               state_d      = DRAW;
`endif
            end
         end
`ifdef ENEMY_SPRITE_ERASE_EN
         ERASE: begin
            if (last_px) begin
               col_d   = '0;
               row_d   = '0;
               state_d = DRAW;
            end else if (col_q == COL_LAST) begin
               col_d = '0;
               row_d = row_q + CNT_W'(1);
            end else begin
               col_d = col_q + CNT_W'(1);
            end
         end
`endif
         DRAW: begin
            if (last_px) begin
               col_d   = '0;
               row_d   = '0;
               state_d = DONE;
`ifdef ENEMY_SPRITE_ERASE_EN
               prev_x_d     = new_x_q;
               prev_y_d     = new_y_q;
               prev_valid_d = 1'b1;
`endif
            end else if (col_q == COL_LAST) begin
               col_d = '0;
               row_d = row_q + CNT_W'(1);
            end else begin
               col_d = col_q + CNT_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Pixel address of the next cycle's scan position; wide sums never wrap
      base_x     = new_x_d;
      base_y     = new_y_d;
      pix_colour = new_colour_d;
      in_pass    = (state_d == DRAW);
`ifdef ENEMY_SPRITE_ERASE_EN
      if (state_d == ERASE) begin
         base_x     = prev_x_q;
         base_y     = prev_y_q;
         pix_colour = BG_COLOUR;
         in_pass    = 1'b1;
      end
`endif
      pix_x = (X_W+1)'(base_x) + (X_W+1)'(col_d);
      pix_y = (Y_W+1)'(base_y) + (Y_W+1)'(row_d);

      // Clipped pixels consume the cycle but never reach the VGA port
      plot_d       = in_pass && (pix_x <= (X_W+1)'(X_MAX)) && (pix_y <= (Y_W+1)'(Y_MAX));
      vga_x_d      = plot_d ? pix_x[X_W-1:0] : vga_x_q;
      vga_y_d      = plot_d ? pix_y[Y_W-1:0] : vga_y_q;
      vga_colour_d = plot_d ? pix_colour     : vga_colour_q;
      busy_d       = (state_d != IDLE);
      done_d       = (state_d == DONE);
   end

   assign busy       = busy_q;
   assign plot       = plot_q;
   assign vga_x      = vga_x_q;
   assign vga_y      = vga_y_q;
   assign vga_colour = vga_colour_q;
   assign done       = done_q;

endmodule
